lfsr_encrypter: RTL and testbench

LFSR_ENCRYPTER -- requirements
Module: lfsr_encrypter

---
 rtl/lfsr_encrypter.sv | 184 ++++++++++++++++++
 tb/tb_lfsr_encrypter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_encrypter.sv
// Frame encrypter: writes a preamble, the plaintext and padding to memory, each byte XORed with a 6-bit LFSR keystream.
// The LFSR advances only on bytes actually written, so plaintext stalls never consume keystream.
module lfsr_encrypter #(
    parameter int          FRAME_LEN = 64,
    parameter int          BASE_ADDR = 64,
    parameter logic [7:0]  PRE_CHAR  = 8'h5F,
    parameter logic [7:0]  PAD_CHAR  = 8'h20
) (
    input  logic       clk,
    input  logic       init,
    input  logic       start,
    input  logic [2:0] taps_sel,
    input  logic [5:0] seed,
    input  logic [3:0] pre_len,
    input  logic       pt_valid,
    input  logic [7:0] pt_data,
    input  logic       pt_last,
    output logic       pt_ready,
    output logic       wr_en,
    output logic [7:0] waddr,
    output logic [7:0] data_out,
    output logic       done,
    output logic       err
);

    // state | meaning
    // IDLE  | waiting for start after init
    // PRE   | writing preamble characters
    // MSG   | accepting and writing plaintext bytes
    // PAD   | filling the rest of the frame with pad characters
    // DONE  | frame finished or start rejected; start begins a new frame
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_MSG, S_PAD, S_DONE} state_t;

    localparam logic [7:0] LAST_K = 8'(FRAME_LEN - 1);
    localparam logic [7:0] BASE_A = 8'(BASE_ADDR % 256);

    state_t     state_q, state_d;
    logic [7:0] k_q, k_d;
    logic [5:0] lfsr_q, lfsr_d;
    logic [5:0] taps_q, taps_d;
    logic [3:0] plen_q, plen_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] waddr_q, waddr_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       cfg_bad;
    logic       wr;
    logic [7:0] wr_k;
    logic [5:0] wr_s;
    logic [5:0] wr_t;
    logic [7:0] wr_char;

    function automatic logic [5:0] tap_decode(input logic [2:0] sel);
        case (sel)
            3'd0:    return 6'h21;
            3'd1:    return 6'h2D;
            3'd2:    return 6'h30;
            3'd3:    return 6'h33;
            3'd4:    return 6'h36;
            default: return 6'h39;
        endcase
    endfunction

    function automatic logic [5:0] lfsr_step(input logic [5:0] s, input logic [5:0] t);
        return {s[4:0], ^(s & t)};
    endfunction

    assign cfg_bad = (seed == 6'd0) || (taps_sel > 3'd5);

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q <= S_IDLE;
            k_q     <= 8'd0;
            lfsr_q  <= 6'd0;
            taps_q  <= 6'd0;
            plen_q  <= 4'd0;
            wr_en_q <= 1'b0;
            waddr_q <= 8'd0;
            data_q  <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            lfsr_q  <= lfsr_d;
            taps_q  <= taps_d;
            plen_q  <= plen_d;
            wr_en_q <= wr_en_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // The byte written on a transition is registered at that same edge, so the
    // state always leads the memory outputs by one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = cfg_bad ? S_DONE : S_PRE;
            end
            S_PRE: begin
                if (k_q == LAST_K)                       state_d = S_DONE;
                else if ((k_q + 8'd1) == {4'd0, plen_q}) state_d = S_MSG;
            end
            S_MSG: begin
                if (pt_valid) begin
                    if (k_q == LAST_K)  state_d = S_DONE;
                    else if (pt_last)   state_d = S_PAD;
                end
            end
            S_PAD: begin
                if (k_q == LAST_K) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        k_d     = k_q;
        lfsr_d  = lfsr_q;
        taps_d  = taps_q;
        plen_d  = plen_q;
        err_d   = err_q;
        done_d  = (state_q == S_DONE);
        wr_en_d = 1'b0;
        waddr_d = waddr_q;
        data_d  = data_q;
        wr      = 1'b0;
        wr_k    = k_q;
        wr_s    = lfsr_q;
        wr_t    = taps_q;
        wr_char = PRE_CHAR;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        err_d  = 1'b0;
                        done_d = 1'b0;
                        taps_d = tap_decode(taps_sel);
                        plen_d = (pre_len < 4'd7) ? 4'd7 : pre_len;
                        wr     = 1'b1;
                        wr_k   = 8'd0;
                        wr_s   = seed;
                        wr_t   = tap_decode(taps_sel);
                    end
                end
            end
            S_PRE: wr = 1'b1;
            S_MSG: begin
                if (pt_valid) begin
                    wr      = 1'b1;
                    wr_char = pt_data;
                end
            end
            S_PAD: begin
                wr      = 1'b1;
                wr_char = PAD_CHAR;
            end
            default: ;
        endcase
        if (wr) begin
            wr_en_d = 1'b1;
            waddr_d = BASE_A + wr_k;
            data_d  = wr_char ^ {2'b00, wr_s};
            k_d     = wr_k + 8'd1;
            lfsr_d  = lfsr_step(wr_s, wr_t);
        end
    end

    assign pt_ready = (state_q == S_MSG);
    assign wr_en    = wr_en_q;
    assign waddr    = waddr_q;
    assign data_out = data_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_lfsr_encrypter.sv
// Bench for lfsr_encrypter: a frame table drives whole frames, a reference model queues
// every expected memory write, and a negedge monitor pops and compares them.
module tb_lfsr_encrypter;

    localparam int FL = 64;

    logic       clk = 1'b0;
    logic       init = 1'b0;
    logic       start = 1'b0;
    logic [2:0] taps_sel = 3'd0;
    logic [5:0] seed = 6'd0;
    logic [3:0] pre_len = 4'd0;
    logic       pt_valid = 1'b0;
    logic [7:0] pt_data = 8'd0;
    logic       pt_last = 1'b0;
    logic       pt_ready;
    logic       wr_en;
    logic [7:0] waddr;
    logic [7:0] data_out;
    logic       done;
    logic       err;

    lfsr_encrypter #(
        .FRAME_LEN(FL), .BASE_ADDR(64), .PRE_CHAR(8'h5F), .PAD_CHAR(8'h20)
    ) dut (
        .clk(clk), .init(init), .start(start), .taps_sel(taps_sel), .seed(seed),
        .pre_len(pre_len), .pt_valid(pt_valid), .pt_data(pt_data), .pt_last(pt_last),
        .pt_ready(pt_ready), .wr_en(wr_en), .waddr(waddr), .data_out(data_out),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] seed;
        logic [2:0] sel;
        logic [3:0] plen;
        int         n;
        int         stall_at;
        int         stall_len;
        bit         poke;
        bit         exp_err;
        int         exp_acc;
        int         exp_wr;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  msg [0:63];
    logic [5:0]  tap_tab [0:5];
    int          fr_writes, first_wr, last_wr, done_rise;
    logic [7:0]  log_a [0:2];
    logic [7:0]  log_d [0:2];
    logic        done_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_en) begin
            if (fr_writes == 0) first_wr = cyc;
            last_wr = cyc;
            if (fr_writes < 3) begin
                log_a[fr_writes] = waddr;
                log_d[fr_writes] = data_out;
            end
            fr_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {waddr, data_out}, 0);
            end else begin
                check("wr_addr_data", {waddr, data_out}, exp_q.pop_front());
            end
        end
        if (done && !done_prev) done_rise = cyc;
        done_prev = done;
    end

    task automatic expect_frame(input logic [5:0] sd, input logic [2:0] sel,
                                input logic [3:0] pl, input int n);
        logic [5:0] s;
        logic [5:0] t;
        logic [7:0] ch;
        int         pe;
        s  = sd;
        t  = tap_tab[sel];
        pe = (pl < 4'd7) ? 7 : int'(pl);
        for (int k = 0; k < FL; k++) begin
            if (k < pe)          ch = 8'h5F;
            else if (k - pe < n) ch = msg[k - pe];
            else                 ch = 8'h20;
            exp_q.push_back({8'((64 + k) % 256), ch ^ {2'b00, s}});
            s = {s[4:0], ^(s & t)};
        end
    endtask

    task automatic run_frame(input vec_t v);
        int   i, c, w, start_cyc, stall_left;
        logic rdy, stalled;
        fr_writes = 0; first_wr = -1; last_wr = -1; done_rise = -1;
        if (v.seed != 6'd0 && v.sel <= 3'd5) expect_frame(v.seed, v.sel, v.plen, v.n);
        seed = v.seed; taps_sel = v.sel; pre_len = v.plen; start = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
        i = 0; c = 0; stall_left = v.stall_len;
        while (i < v.n && c < 400) begin
            stalled  = (i == v.stall_at) && (stall_left > 0);
            pt_valid = !stalled;
            pt_data  = msg[i];
            pt_last  = (i == v.n - 1);
            start    = v.poke && (i == 3);
            @(negedge clk);
            rdy = pt_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (stalled)  stall_left--;
            else if (rdy) i++;
            c++;
            if (done) break;
        end
        pt_valid = 1'b0; pt_last = 1'b0;
        w = 0;
        while (!done && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        @(negedge clk); #1;
        check("err", err, v.exp_err);
        check("done", done, 1);
        check("accepted", i, v.exp_acc);
        check("writes", fr_writes, v.exp_wr);
        check("pt_ready_low", pt_ready, 0);
        check("queue_empty", exp_q.size(), 0);
        if (v.exp_wr > 0) begin
            check("first_wr_latency", first_wr, start_cyc);
            check("wr_span", last_wr - first_wr + 1, v.exp_wr + v.stall_len);
            check("done_rise", done_rise, last_wr + 1);
        end
    endtask

    vec_t vecs[9];
    vec_t post_vec;

    initial begin
        int   i, c, wr_before;
        logic rdy;
        tap_tab[0] = 6'h21; tap_tab[1] = 6'h2D; tap_tab[2] = 6'h30;
        tap_tab[3] = 6'h33; tap_tab[4] = 6'h36; tap_tab[5] = 6'h39;
        for (int j = 0; j < 64; j++) msg[j] = 8'((j * 73 + 29) ^ (j << 6));
        //             seed   sel   plen  n  stall len poke err acc wr
        vecs[0] = '{6'h01, 3'd0, 4'd7,  10, -1, 0, 1'b0, 1'b0, 10, 64};
        vecs[1] = '{6'h01, 3'd0, 4'd7,  10,  4, 3, 1'b0, 1'b0, 10, 64};
        vecs[2] = '{6'h00, 3'd0, 4'd7,  10, -1, 0, 1'b0, 1'b1,  0,  0};
        vecs[3] = '{6'h2A, 3'd6, 4'd7,  10, -1, 0, 1'b0, 1'b1,  0,  0};
        vecs[4] = '{6'h2A, 3'd3, 4'd7,  60, -1, 0, 1'b0, 1'b0, 57, 64};
        vecs[5] = '{6'h3F, 3'd5, 4'd2,   5, -1, 0, 1'b1, 1'b0,  5, 64};
        vecs[6] = '{6'h15, 3'd2, 4'd12, 20,  7, 2, 1'b0, 1'b0, 20, 64};
        vecs[7] = '{6'h33, 3'd1, 4'd9,  55, -1, 0, 1'b0, 1'b0, 55, 64};
        vecs[8] = '{6'h01, 3'd4, 4'd7,  57, -1, 0, 1'b0, 1'b0, 57, 64};
        post_vec = '{6'h11, 3'd2, 4'd8, 30, -1, 0, 1'b0, 1'b0, 30, 64};

        #1 init = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_waddr", waddr, 0);
        check("rst_data_out", data_out, 0);
        check("rst_pt_ready", pt_ready, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1 init = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            run_frame(vecs[v]);
            if (v == 0) begin
                check("first_byte", {log_a[0], log_d[0]}, 16'h405E);
                check("second_byte", {log_a[1], log_d[1]}, 16'h415C);
                check("third_byte", {log_a[2], log_d[2]}, 16'h4258);
            end
        end

        // abandon a frame mid-message with init, then run a clean frame from IDLE
        fr_writes = 0;
        expect_frame(post_vec.seed, post_vec.sel, post_vec.plen, post_vec.n);
        seed = post_vec.seed; taps_sel = post_vec.sel; pre_len = post_vec.plen; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        i = 0; c = 0; pt_valid = 1'b1; pt_last = 1'b0;
        while (fr_writes < 12 && c < 100) begin
            pt_data = msg[i];
            @(negedge clk);
            rdy = pt_ready;
            @(posedge clk); #1;
            if (rdy) i++;
            c++;
        end
        @(negedge clk);
        check("init_in_msg", pt_ready, 1);
        #2 init = 1'b1;
        #1;
        check("init_wr_en", wr_en, 0);
        check("init_waddr", waddr, 0);
        check("init_data_out", data_out, 0);
        check("init_pt_ready", pt_ready, 0);
        check("init_done", done, 0);
        check("init_err", err, 0);
        exp_q.delete();
        pt_valid = 1'b0;
        wr_before = fr_writes;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 init = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_write_after_init", fr_writes, wr_before);
        check("idle_done_low", done, 0);
        run_frame(post_vec);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
